rgb565_gray_stream_ctrl: RTL and testbench

//  Frame-level sequencer around the RGB565->grayscale datapath: takes a run of 32-bit

---
 rtl/rgb565_gray_stream_ctrl.sv | 175 +++++++++++++++++
 tb/tb_rgb565_gray_stream_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb565_gray_stream_ctrl.sv
// rgb565_gray_stream_ctrl
//   Frame sequencer around an RGB565 -> 8-bit grayscale converter. Accepts 32-bit
//   words carrying two RGB565 pixels each, converts both pixels, and packs four gray
//   bytes per 32-bit output word. An odd number of pixel pairs ends with a
//   zero-padded flush word. Software arms a frame with start/pixelCount and
//   watches busy/done.
//   Optional feature macro: RGB565_GRAY_THRESHOLD_EN (adds an 8-bit threshold port
//   and binarises each gray byte to 8'hFF / 8'h00).
module rgb565_gray_stream_ctrl #(
  parameter int CNT_WIDTH = 20
) (
  input  logic                 clock,
  input  logic                 nReset,
  input  logic                 start,
  input  logic [CNT_WIDTH-1:0] pixelCount,
`ifdef RGB565_GRAY_THRESHOLD_EN
  input  logic [7:0]           threshold,
`endif
  output logic                 busy,
  output logic                 done,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [31:0]          s_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [31:0]          m_data
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] remaining_q, remaining_d;
  logic                 half_q, half_d;
  logic [15:0]          half_buf_q, half_buf_d;
  logic                 m_valid_q, m_valid_d;
  logic [31:0]          m_data_q, m_data_d;
  logic                 done_q, done_d;
  logic [7:0]           gray0, gray1;
  logic                 accept;
`ifdef RGB565_GRAY_THRESHOLD_EN
  logic [7:0]           thr_q, thr_d;
`endif

  // Expand RGB565 to 8 bits per channel by replication, then weight and truncate.
  // The weights sum to 256, so the worst case (all 255) is 65280 and fits 16 bits.
  function automatic logic [7:0] gray565(input logic [15:0] px);
    logic [7:0]  r8, g8, b8;
    logic [15:0] acc;
    r8  = {px[15:11], px[15:13]};
    g8  = {px[10:5], px[10:9]};
    b8  = {px[4:0], px[4:2]};
    acc = 16'd54 * 16'(r8) + 16'd183 * 16'(g8) + 16'd19 * 16'(b8);
    return acc[15:8];
  endfunction

  // Per-pixel gray bytes for the word currently offered on the input.
  always_comb begin
    gray0 = gray565(s_data[31:16]);
    gray1 = gray565(s_data[15:0]);
`ifdef RGB565_GRAY_THRESHOLD_EN
    gray0 = (gray0 >= thr_q) ? 8'hFF : 8'h00;
    gray1 = (gray1 >= thr_q) ? 8'hFF : 8'h00;
`endif
  end

  // Next-state, handshake and output-word loading for the frame sequencer.
  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    half_d      = half_q;
    half_buf_d  = half_buf_q;
    m_valid_d   = m_valid_q & ~m_ready;
    m_data_d    = m_data_q;
    done_d      = 1'b0;
    s_ready     = 1'b0;
    accept      = 1'b0;
`ifdef RGB565_GRAY_THRESHOLD_EN
    thr_d       = thr_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          remaining_d = {pixelCount[CNT_WIDTH-1:1], 1'b0};
          half_d      = 1'b0;
`ifdef RGB565_GRAY_THRESHOLD_EN
          thr_d       = threshold;
`endif
          state_d     = (pixelCount[CNT_WIDTH-1:1] == '0) ? ST_DRAIN : ST_RUN;
        end
      end

      ST_RUN: begin
        // A completing word needs the output register free (or freeing this cycle);
        // a first-half word only needs the half-buffer.
        s_ready = (remaining_q != '0) && (!half_q || !m_valid_q || m_ready);
        accept  = s_valid && s_ready;
        if (accept) begin
          remaining_d = remaining_q - CNT_WIDTH'(2);
          if (!half_q) begin
            half_buf_d = {gray0, gray1};
            half_d     = 1'b1;
          end else begin
            m_data_d   = {half_buf_q, gray0, gray1};
            m_valid_d  = 1'b1;
            half_d     = 1'b0;
          end
          if (remaining_q == CNT_WIDTH'(2)) begin
            state_d = half_d ? ST_FLUSH : ST_DRAIN;
          end
        end
      end

      ST_FLUSH: begin
        if (!m_valid_q || m_ready) begin
          m_data_d  = {half_buf_q, 16'h0000};
          m_valid_d = 1'b1;
          half_d    = 1'b0;
          state_d   = ST_DRAIN;
        end
      end

      ST_DRAIN: begin
        if (!m_valid_q || m_ready) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any frame in progress.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      half_q      <= 1'b0;
      half_buf_q  <= '0;
      m_valid_q   <= 1'b0;
      m_data_q    <= '0;
      done_q      <= 1'b0;
`ifdef RGB565_GRAY_THRESHOLD_EN
      thr_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      half_q      <= half_d;
      half_buf_q  <= half_buf_d;
      m_valid_q   <= m_valid_d;
      m_data_q    <= m_data_d;
      done_q      <= done_d;
`ifdef RGB565_GRAY_THRESHOLD_EN
      thr_q       <= thr_d;
`endif
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;

endmodule

// File: tb/tb_rgb565_gray_stream_ctrl.sv
// tb_rgb565_gray_stream_ctrl
//   Self-checking bench: directed frames with known answers plus randomized frames
//   (random data, random valid/ready) scored against an integer reference model.
//   Honours RGB565_GRAY_THRESHOLD_EN when defined.
module tb_rgb565_gray_stream_ctrl;

  localparam int CW = 20;

  logic          clock = 1'b0;
  logic          nReset;
  logic          start;
  logic [CW-1:0] pixelCount;
  logic [7:0]    thr;
  logic          busy, done;
  logic          s_valid, s_ready;
  logic [31:0]   s_data;
  logic          m_valid, m_ready;
  logic [31:0]   m_data;

  int n_checks = 0;
  int n_pass   = 0;
  int stall_accepts;

  logic [31:0] in_q[$];
  logic [31:0] exp_q[$];

  rgb565_gray_stream_ctrl #(.CNT_WIDTH(CW)) dut (
    .clock      (clock),
    .nReset     (nReset),
    .start      (start),
    .pixelCount (pixelCount),
`ifdef RGB565_GRAY_THRESHOLD_EN
    .threshold  (thr),
`endif
    .busy       (busy),
    .done       (done),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference gray value from the channel arithmetic, in plain integers.
  function automatic int ref_gray(input int px);
    int r, g, b;
    r = (px >> 11) & 31;
    g = (px >> 5) & 63;
    b = px & 31;
    r = r * 8 + r / 4;
    g = g * 4 + g / 16;
    b = b * 8 + b / 4;
    return (54 * r + 183 * g + 19 * b) / 256;
  endfunction

  function automatic int ref_byte(input int px);
    int y;
    y = ref_gray(px);
`ifdef RGB565_GRAY_THRESHOLD_EN
    return (y >= int'(thr)) ? 255 : 0;
`else
    return y;
`endif
  endfunction

  // Expected output words for the words currently queued on the input side.
  task automatic build_expected();
    int bytes[$];
    logic [31:0] w;
    foreach (in_q[i]) begin
      bytes.push_back(ref_byte(int'(in_q[i][31:16])));
      bytes.push_back(ref_byte(int'(in_q[i][15:0])));
    end
    while (bytes.size() % 4 != 0) bytes.push_back(0);
    for (int i = 0; i < bytes.size(); i += 4) begin
      w = {8'(bytes[i]), 8'(bytes[i+1]), 8'(bytes[i+2]), 8'(bytes[i+3])};
      exp_q.push_back(w);
    end
  endtask

  task automatic fill_random(input int nwords);
    for (int i = 0; i < nwords; i++) in_q.push_back($urandom);
    build_expected();
  endtask

  task automatic do_reset();
    @(negedge clock);
    nReset = 1'b0;
    start = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
    @(negedge clock);
    nReset = 1'b1;
    in_q.delete();
    exp_q.delete();
  endtask

  // Run one frame: in_q holds exactly the words the frame consumes, exp_q the
  // words it must produce. vpct/rpct are valid/ready percentages; m_ready is
  // held low for the first 'stall' cycles; mid_start pulses start mid-frame.
  task automatic run_frame(input int npix, input int vpct, input int rpct,
                           input int stall, input bit mid_start);
    int          last_hs, done_it, n_exp;
    bit          hold;
    logic [31:0] hold_data;
    n_exp = exp_q.size();
    last_hs = -1; done_it = -1; hold = 1'b0; hold_data = '0; stall_accepts = 0;
    @(negedge clock);
    start = 1'b1;
    pixelCount = CW'(npix);
    @(posedge clock);
    #1;
    start = 1'b0;
    check("busy_after_start", 32'(busy), 1);
    for (int it = 0; it < 3000; it++) begin
      @(negedge clock);
      start = mid_start && (it == 3);
      pixelCount = CW'($urandom_range(2, 30));
      s_valid = (in_q.size() > 0) && ($urandom_range(0, 99) < vpct);
      s_data = (in_q.size() > 0) ? in_q[0] : $urandom;
      m_ready = (it >= stall) && ($urandom_range(0, 99) < rpct);
      #1;
      if (done) begin
        start = 1'b0;
        done_it = it;
        break;
      end
      if (hold) begin
        check("m_valid_held", 32'(m_valid), 1);
        check("m_data_stable", m_data, hold_data);
      end
      check("s_ready_without_words", 32'(s_ready && in_q.size() == 0), 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_output_word", 32'(m_valid), 0);
        else check("m_data", m_data, exp_q.pop_front());
        last_hs = it;
      end
      if (s_valid && s_ready) begin
        void'(in_q.pop_front());
        if (it < stall) stall_accepts++;
      end
      hold = m_valid && !m_ready;
      hold_data = m_data;
    end
    s_valid = 1'b0;
    m_ready = 1'b0;
    check("done_seen", 32'(done_it >= 0), 1);
    check("done_latency", 32'(done_it), 32'((n_exp == 0) ? 1 : last_hs + 1));
    check("inputs_consumed", 32'(in_q.size()), 0);
    check("outputs_delivered", 32'(exp_q.size()), 0);
    check("busy_at_done", 32'(busy), 0);
    @(posedge clock);
    #1;
    check("done_one_cycle", 32'(done), 0);
    if (done_it < 0) do_reset();
  endtask

  initial begin
    nReset = 1'b0; start = 1'b0; pixelCount = '0; thr = 8'h40;
    s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
    #12;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_m_valid", 32'(m_valid), 0);
    check("rst_m_data", m_data, 0);
    check("rst_s_ready", 32'(s_ready), 0);
    @(negedge clock);
    nReset = 1'b1;

    // Known-answer: primary colours and white.
    in_q = '{32'hF800_07E0, 32'h001F_FFFF};
`ifdef RGB565_GRAY_THRESHOLD_EN
    exp_q = '{32'h00FF_00FF};
`else
    exp_q = '{32'h35B6_12FF};
`endif
    run_frame(4, 100, 100, 0, 1'b0);

    // Black and white, two output words in order.
    in_q = '{32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000};
    exp_q = '{32'h00FF_FF00, 32'h00FF_FF00};
    run_frame(8, 100, 100, 0, 1'b0);

    // Single pair: zero-padded flush word.
    in_q = '{32'hFFFF_FFFF};
    exp_q = '{32'hFFFF_0000};
    run_frame(2, 100, 100, 0, 1'b0);

    // Backpressure: one full word plus a half are taken, then input stalls.
    fill_random(8);
    run_frame(16, 100, 100, 10, 1'b0);
    check("stall_accepts", 32'(stall_accepts), 3);

    // Empty frames (bit 0 of pixelCount is ignored).
    run_frame(0, 100, 100, 0, 1'b0);
    run_frame(1, 100, 100, 0, 1'b0);

    // Odd pixelCount rounds down to pairs; start while busy is ignored.
    fill_random(5);
    run_frame(11, 100, 100, 0, 1'b1);

    // Randomized frames with random throttling on both sides.
    for (int f = 0; f < 20; f++) begin
      int npix;
      npix = $urandom_range(0, 41);
      thr = 8'($urandom);
      fill_random(npix / 2);
      run_frame(npix, $urandom_range(30, 100), $urandom_range(30, 100), 0,
                (npix >= 16) && (f % 2 == 0));
    end

    // Reset mid-frame drops everything, with no done pulse afterwards.
    @(negedge clock);
    start = 1'b1;
    pixelCount = CW'(16);
    @(negedge clock);
    start = 1'b0;
    s_valid = 1'b1;
    s_data = $urandom;
    m_ready = 1'b0;
    repeat (3) @(negedge clock);
    nReset = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 0);
    check("abort_m_valid", 32'(m_valid), 0);
    check("abort_done", 32'(done), 0);
    check("abort_s_ready", 32'(s_ready), 0);
    @(negedge clock);
    nReset = 1'b1;
    s_valid = 1'b0;
    @(negedge clock);
    #1;
    check("post_abort_done", 32'(done), 0);
    check("post_abort_busy", 32'(busy), 0);

    // Clean frame after the abort.
    thr = 8'h40;
    in_q = '{32'hFFFF_FFFF};
    exp_q = '{32'hFFFF_0000};
    run_frame(2, 100, 100, 0, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
